// File: rtl/arith_op_sequencer.sv
// Operand/operation sequencer for the float/fixed adder-multiplier units.
// Captures operands, launches an op, waits LAT settle cycles and registers the chosen unit's result.
module arith_op_sequencer #(
   parameter int WIDTH = 16,
   parameter int LAT   = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         op_in,
   input  logic               op_valid,
   input  logic               chain,
   output logic [WIDTH-1:0]   opa,
   output logic [WIDTH-1:0]   opb,
   output logic [1:0]         op_sel,
   input  logic [4*WIDTH-1:0] res_in,
   input  logic [15:0]        flag_in,
   output logic [WIDTH-1:0]   result,
   output logic [3:0]         flags,
   output logic [3:0]         sticky,
   input  logic               sticky_clr,
   output logic               res_valid,
   output logic               busy,
   output logic [2:0]         state
);

   typedef enum logic [2:0] {
      S_WAIT_A = 3'd0,
      S_WAIT_B = 3'd1,
      S_ARMED  = 3'd2,
      S_EXEC   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [3:0] LAT_CNT = 4'(LAT);

   state_t           r_state;
   logic [3:0]       r_cnt;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [1:0]       r_op_sel;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_flags;
   logic [3:0]       r_sticky;
   logic             r_res_valid;

   state_t           w_state_nxt;
   logic [3:0]       w_cnt_nxt;
   logic [WIDTH-1:0] w_opa_nxt;
   logic [WIDTH-1:0] w_opb_nxt;
   logic [1:0]       w_op_sel_nxt;
   logic [WIDTH-1:0] w_result_nxt;
   logic [3:0]       w_flags_nxt;
   logic [3:0]       w_sticky_nxt;
   logic             w_res_valid_nxt;
   logic [WIDTH-1:0] w_res_sel;
   logic [3:0]       w_flag_sel;
   logic [3:0]       w_sticky_base;

   assign w_res_sel     = res_in[WIDTH*int'(r_op_sel) +: WIDTH];
   assign w_flag_sel    = flag_in[4*int'(r_op_sel) +: 4];
   assign w_sticky_base = sticky_clr ? 4'b0000 : r_sticky;

   always_comb begin
      // NOTE: every next-value gets a default before the case so no path leaves it unassigned (no latches).
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_opa_nxt       = r_opa;
      w_opb_nxt       = r_opb;
      w_op_sel_nxt    = r_op_sel;
      w_result_nxt    = r_result;
      w_flags_nxt     = r_flags;
      w_sticky_nxt    = w_sticky_base;
      w_res_valid_nxt = 1'b0;

      case (r_state)
         S_WAIT_A: begin
            if (in_valid) begin
               w_opa_nxt   = in_data;
               w_state_nxt = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            if (in_valid) begin
               w_opb_nxt   = in_data;
               w_state_nxt = S_ARMED;
            end
         end
         S_ARMED: begin
            if (op_valid) begin
               w_op_sel_nxt = op_in;
               w_cnt_nxt    = LAT_CNT;
               w_state_nxt  = S_EXEC;
            end else if (in_valid) begin
               w_opb_nxt = in_data;
            end
         end
         S_EXEC: begin
            if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else begin
               // A clear coinciding with capture still keeps the newly captured flags.
               w_result_nxt    = w_res_sel;
               w_flags_nxt     = w_flag_sel;
               w_sticky_nxt    = w_sticky_base | w_flag_sel;
               w_res_valid_nxt = 1'b1;
               w_state_nxt     = S_DONE;
            end
         end
         S_DONE: begin
            if (in_valid) begin
               if (chain) begin
                  w_opa_nxt   = r_result;
                  w_opb_nxt   = in_data;
                  w_state_nxt = S_ARMED;
               end else begin
                  w_opa_nxt   = in_data;
                  w_state_nxt = S_WAIT_B;
               end
            end else if (op_valid) begin
               w_op_sel_nxt = op_in;
               w_cnt_nxt    = LAT_CNT;
               w_state_nxt  = S_EXEC;
            end
         end
         default: w_state_nxt = S_WAIT_A;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_WAIT_A;
         r_cnt       <= 4'd0;
         r_opa       <= '0;
         r_opb       <= '0;
         r_op_sel    <= 2'd0;
         r_result    <= '0;
         r_flags     <= 4'd0;
         r_sticky    <= 4'd0;
         r_res_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_opa       <= w_opa_nxt;
         r_opb       <= w_opb_nxt;
         r_op_sel    <= w_op_sel_nxt;
         r_result    <= w_result_nxt;
         r_flags     <= w_flags_nxt;
         r_sticky    <= w_sticky_nxt;
         r_res_valid <= w_res_valid_nxt;
      end
   end

   assign in_ready  = (r_state != S_EXEC);
   assign busy      = (r_state == S_EXEC);
   assign state     = r_state;
   assign opa       = r_opa;
   assign opb       = r_opb;
   assign op_sel    = r_op_sel;
   assign result    = r_result;
   assign flags     = r_flags;
   assign sticky    = r_sticky;
   assign res_valid = r_res_valid;

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Scoreboard bench for arith_op_sequencer: LAT=2 instance for the main flow, LAT=5 instance for reset abort.
module tb_arith_op_sequencer;

   localparam int W   = 16;
   localparam int LAT = 2;

   typedef struct {
      logic [W-1:0] res;
      logic [3:0]   flg;
      int           op_cyc;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst, rst5;
   logic [W-1:0]   in_data;
   logic           in_valid, op_valid, in_valid5, op_valid5;
   logic [1:0]     op_in;
   logic           chain, sticky_clr;
   logic [4*W-1:0] res_in;
   logic [15:0]    flag_in;

   logic           in_ready, res_valid, busy;
   logic [W-1:0]   opa, opb, result;
   logic [1:0]     op_sel;
   logic [3:0]     flags, sticky;
   logic [2:0]     state;

   logic           in_ready5, res_valid5, busy5;
   logic [W-1:0]   opa5, opb5, result5;
   logic [1:0]     op_sel5;
   logic [3:0]     flags5, sticky5;
   logic [2:0]     state5;

   exp_t q[$];
   int   n_total = 0;
   int   n_bad   = 0;
   int   cyc     = 0;
   int   busy_cnt = 0;
   int   rv5_cnt  = 0;

   arith_op_sequencer #(.WIDTH(W), .LAT(LAT)) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .op_in(op_in), .op_valid(op_valid), .chain(chain), .opa(opa), .opb(opb), .op_sel(op_sel),
      .res_in(res_in), .flag_in(flag_in), .result(result), .flags(flags), .sticky(sticky),
      .sticky_clr(sticky_clr), .res_valid(res_valid), .busy(busy), .state(state)
   );

   arith_op_sequencer #(.WIDTH(W), .LAT(5)) u_dut5 (
      .clk(clk), .rst(rst5), .in_data(in_data), .in_valid(in_valid5), .in_ready(in_ready5),
      .op_in(op_in), .op_valid(op_valid5), .chain(chain), .opa(opa5), .opb(opb5), .op_sel(op_sel5),
      .res_in(res_in), .flag_in(flag_in), .result(result5), .flags(flags5), .sticky(sticky5),
      .sticky_clr(sticky_clr), .res_valid(res_valid5), .busy(busy5), .state(state5)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: each res_valid pulse must match the oldest launched op; latency counted in edges.
   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (res_valid5) rv5_cnt++;
      if (res_valid) begin
         if (q.size() == 0) begin
            check("spurious_res_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("flags", 32'(flags), 32'(e.flg));
            check("latency", 32'(cyc - e.op_cyc), 32'(LAT + 1));
         end
      end
   end

   task automatic send_word(input logic [W-1:0] d);
      in_data  = d;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Launch op on the LAT=2 DUT; optionally with a simultaneous in_valid carrying d.
   task automatic send_op(input logic [1:0] op, input logic [W-1:0] r, input logic [3:0] f,
                          input logic also_in, input logic [W-1:0] d);
      exp_t e;
      res_in[W*op +: W]  = r;
      flag_in[4*op +: 4] = f;
      op_in    = op;
      op_valid = 1'b1;
      in_valid = also_in;
      in_data  = d;
      @(posedge clk); #1;
      op_valid = 1'b0;
      in_valid = 1'b0;
      e.res    = r;
      e.flg    = f;
      e.op_cyc = cyc;
      q.push_back(e);
   endtask

   task automatic wait_rv();
      for (int i = 0; i < 40; i++) begin
         if (q.size() == 0) break;
         @(negedge clk); #1;
      end
      check("rv_timeout_pending", 32'(q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; rst5 = 1'b1;
      in_data = '0; in_valid = 1'b0; op_valid = 1'b0; in_valid5 = 1'b0; op_valid5 = 1'b0;
      op_in = 2'd0; chain = 1'b0; sticky_clr = 1'b0; res_in = '0; flag_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_opa", 32'(opa), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags_sticky", {24'd0, flags, sticky}, 32'd0);
      check("rst_rv_busy_ready", {29'd0, res_valid, busy, in_ready}, 32'd1);
      rst = 1'b0; rst5 = 1'b0;
      @(posedge clk); #1;

      // op_valid ignored in WAIT_A and WAIT_B
      op_in = 2'd1; op_valid = 1'b1; @(posedge clk); #1; op_valid = 1'b0;
      check("opv_in_wait_a", 32'(state), 32'd0);
      send_word(16'h3C00);
      check("state_wait_b", 32'(state), 32'd1);
      op_valid = 1'b1; @(posedge clk); #1; op_valid = 1'b0;
      check("opv_in_wait_b", 32'(state), 32'd1);
      send_word(16'h4000);
      check("armed_ops", {opa, opb}, 32'h3C00_4000);
      check("state_armed", 32'(state), 32'd2);

      // basic float add, LAT=2
      busy_cnt = 0;
      send_op(2'd0, 16'h4200, 4'b0000, 1'b0, '0);
      wait_rv();
      check("busy_cycles", 32'(busy_cnt), 32'(LAT + 1));
      check("op_sel_0", 32'(op_sel), 32'd0);
      check("state_done", 32'(state), 32'd4);

      // re-execute on held operands
      send_op(2'd1, 16'h4000, 4'b0000, 1'b0, '0);
      wait_rv();
      check("reexec_ops", {opa, opb}, 32'h3C00_4000);
      check("op_sel_1", 32'(op_sel), 32'd1);

      // chain: previous result becomes operand A
      chain = 1'b1;
      send_word(16'h0100);
      chain = 1'b0;
      check("chain_ops", {opa, opb}, 32'h4000_0100);
      check("chain_state", 32'(state), 32'd2);
      send_op(2'd2, 16'h4300, 4'b0000, 1'b0, '0);
      wait_rv();

      // flags and sticky accumulation
      send_op(2'd3, 16'h1111, 4'b1001, 1'b0, '0);
      wait_rv();
      check("sticky_after_1001", 32'(sticky), 32'b1001);
      send_op(2'd2, 16'h2222, 4'b0000, 1'b0, '0);
      wait_rv();
      check("sticky_held", {24'd0, flags, sticky}, 32'b0000_1001);

      // sticky_clr on the capture edge: capture wins, sticky = new flags
      send_op(2'd0, 16'h3333, 4'b0100, 1'b0, '0);
      @(posedge clk); @(posedge clk); #1;
      sticky_clr = 1'b1;
      @(posedge clk); #1;
      sticky_clr = 1'b0;
      wait_rv();
      check("sticky_clr_capture", 32'(sticky), 32'b0100);
      sticky_clr = 1'b1; @(posedge clk); #1; sticky_clr = 1'b0;
      check("sticky_clr_alone", 32'(sticky), 32'd0);
      check("flags_kept_after_clr", 32'(flags), 32'b0100);

      // both strobes in DONE: in_valid wins, no EXEC
      op_in = 2'd1; in_data = 16'h5555; in_valid = 1'b1; op_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; op_valid = 1'b0;
      check("done_both_state", 32'(state), 32'd1);
      check("done_both_opa", 32'(opa), 32'h5555);
      repeat (6) @(posedge clk);
      #1;
      check("result_held_on_load", 32'(result), 32'h3333);
      send_word(16'h6666);

      // both strobes in ARMED: op_valid wins, opb unchanged
      send_op(2'd3, 16'h4444, 4'b0000, 1'b1, 16'h7777);
      check("armed_both_busy", {30'd0, busy, in_ready}, 32'b10);
      in_data = 16'h8888; in_valid = 1'b1; op_valid = 1'b1; op_in = 2'd0;
      @(posedge clk); #1;
      in_valid = 1'b0; op_valid = 1'b0;
      check("exec_strobe_ignored_state", 32'(state), 32'd3);
      wait_rv();
      check("exec_ops", {opa, opb}, 32'h5555_6666);
      check("exec_op_sel", 32'(op_sel), 32'd3);

      // LAT=5 instance: one full op, then reset mid-EXEC
      in_data = 16'h1234; in_valid5 = 1'b1; @(posedge clk); #1; in_valid5 = 1'b0;
      in_data = 16'h5678; in_valid5 = 1'b1; @(posedge clk); #1; in_valid5 = 1'b0;
      res_in[W*0 +: W] = 16'h9999; flag_in[3:0] = 4'b1000; op_in = 2'd0;
      op_valid5 = 1'b1; @(posedge clk); #1; op_valid5 = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("lat5_rv_count", 32'(rv5_cnt), 32'd1);
      check("lat5_result_sticky", {12'd0, result5, sticky5}, {12'd0, 16'h9999, 4'b1000});
      op_valid5 = 1'b1; @(posedge clk); #1; op_valid5 = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("lat5_mid_exec", 32'(state5), 32'd3);
      rst5 = 1'b1; #1;
      check("abort_state", 32'(state5), 32'd0);
      check("abort_result_sticky", {12'd0, result5, sticky5}, 32'd0);
      check("abort_flags", 32'(flags5), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst5 = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("abort_no_rv", 32'(rv5_cnt), 32'd1);
      check("q_empty_end", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
